encoder_layer_0_attention_self_key_bias_sink: RTL and testbench
===============================================================

# encoder_layer_0_attention_self_key_bias_sink

Write-side counterpart of the key-bias parameter source. It accepts a key-bias tensor streamed in over a valid/ready handshake and stores it beat by beat in an internal RAM. It then serves the tensor through a ROM-style read port with 2-cycle latency. It sits between a host/DMA weight-loading stream and any block that reads key-bias parameters by address, and makes the bias reloadable at runtime instead of fixed at synthesis.

## Interface
- KEY_BIAS_TENSOR_SIZE_DIM_0, 32, elements in the tensor.
- KEY_BIAS_PRECISION_0, 16, bits per element.
- KEY_BIAS_PARALLELISM_DIM_0, 1, elements per beat (dim 0).
- KEY_BIAS_PARALLELISM_DIM_1, 1, elements per beat (dim 1).
- IN_DEPTH, KEY_BIAS_TENSOR_SIZE_DIM_0 / KEY_BIAS_PARALLELISM_DIM_0, beats per tensor, and RAM depth.
- AWIDTH, $clog2(IN_DEPTH)+1, read address width.
- BEAT_W, KEY_BIAS_PRECISION_0 × PARALLELISM_DIM_0 × PARALLELISM_DIM_1, width of one RAM word.

Ports:
- clk  in  1  the single clock; all state updates on its rising edge.
- rst  in  1  reset, asynchronous and active-low.
- data_in  in  [KEY_BIAS_PRECISION_0-1:0] × (PAR_0·PAR_1)  one beat; element j is packed at bits [P·j+P-1 : P·j] of the stored word.
- data_in_valid  in  1  the beat is valid.
- data_in_ready  out  1  the sink accepts a beat.
- reload  in  1  single-cycle request to discard the contents and restart loading.
- loaded  out  1  the full tensor is resident.
- addr0  in  AWIDTH  read address (beat index).
- ce0  in  1  read pipeline enable.
- q0  out  BEAT_W  read data.

## Operation
- The FSM has two states, LOAD and FULL. Reset places it in LOAD.
- Write counter wr_cnt has width $clog2(IN_DEPTH)+1 and resets to 0.
- In LOAD:
  - data_in_ready = 1.
  - On a handshake (valid & ready), the beat is written to mem[wr_cnt].
  - If wr_cnt == IN_DEPTH-1, wr_cnt goes to 0 and the FSM enters FULL. Otherwise wr_cnt increments.
- In FULL:
  - data_in_ready = 0 and loaded = 1.
  - data_in_valid is ignored; no write occurs.
- reload:
  - From either state, reload goes to LOAD, clears wr_cnt to 0 and drops loaded on the next edge.
  - Reload has priority over a handshake in the same cycle: that beat is not written and not counted. Upstream must resend it.
- data_in_ready and loaded are decoded combinationally from the state register only. There is no combinational path from data_in_valid.
- Read path:
  - Stage 1: if ce0, t0 <= (addr0 < IN_DEPTH) ? mem[addr0] : 0.
  - Stage 2: if ce0, q0 <= t0.
  - With ce0 = 0, both stages hold their values.
- Reads are legal in any state. During LOAD they return whatever the RAM holds, stale or new; consumers qualify reads with loaded.
- The RAM has no reset; its contents are undefined until written.

## Timing
- Reset values: data_in_ready = 1, loaded = 0, q0 = 0, t0 = 0, wr_cnt = 0, state LOAD. Assertion and removal of rst take effect asynchronously; the first handshake can occur on the first edge after rst deasserts.
- Write-to-loaded latency:
  - loaded rises in the cycle after the edge that accepts beat IN_DEPTH-1.
  - data_in_ready falls in that same cycle.
  - With continuous valid, loaded rises IN_DEPTH cycles after the first accepted beat.
- Read latency is 2 ce0-enabled edges: addr0 is sampled at edge k and q0 is valid after edge k+1 when ce0 is held at 1.
- Read and write to the same address in the same cycle is read-before-write: stage 1 captures the old value.
- Back-pressure from upstream: gaps in data_in_valid stall wr_cnt. No timeout.
- A reload pulse during FULL sets data_in_ready = 1 in the following cycle.

## Test plan
- Reset then stream beats 0x0000..0x001F (IN_DEPTH = 32) with valid held high:
  - loaded = 1 in the cycle after the 32nd handshake, and data_in_ready = 0 from then on.
  - Reading addr 0..31 with ce0 = 1 returns each value exactly 2 edges after its address.
- Random valid gaps (about 50% duty) while loading 0xA000+i: all 32 words land at the correct addresses, and wr_cnt never advances on a valid = 0 cycle.
- After loaded, drive valid = 1 with 0xFFFF for 10 cycles: no write, and readback is unchanged.
- Assert reload on the same cycle as the handshake for beat 5:
  - loaded = 0 and wr_cnt = 0.
  - A new full stream of 0x5000+i reads back 0x5000+i everywhere.
- Read addr 40 (out of range) → q0 = 0 after 2 edges. Hold ce0 = 0 for 3 cycles → q0 stays constant.
- Assert rst mid-load (after beat 12) asynchronously, between edges:
  - q0 = 0, loaded = 0 and data_in_ready = 1 immediately, without a clock edge.
  - The next 32 beats reload from address 0.

Source files
------------

// File: rtl/encoder_layer_0_attention_self_key_bias_sink.sv
// Reloadable key-bias store: loads one tensor from a valid/ready stream into RAM,
// then serves it through a 2-stage, ce0-gated read port.
module encoder_layer_0_attention_self_key_bias_sink #(
    parameter int unsigned KEY_BIAS_TENSOR_SIZE_DIM_0 = 32,
    parameter int unsigned KEY_BIAS_PRECISION_0       = 16,
    parameter int unsigned KEY_BIAS_PARALLELISM_DIM_0 = 1,
    parameter int unsigned KEY_BIAS_PARALLELISM_DIM_1 = 1,
    localparam int unsigned NPAR     = KEY_BIAS_PARALLELISM_DIM_0 * KEY_BIAS_PARALLELISM_DIM_1,
    localparam int unsigned IN_DEPTH = KEY_BIAS_TENSOR_SIZE_DIM_0 / KEY_BIAS_PARALLELISM_DIM_0,
    localparam int unsigned AWIDTH   = $clog2(IN_DEPTH) + 1,
    localparam int unsigned BEAT_W   = KEY_BIAS_PRECISION_0 * NPAR
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [KEY_BIAS_PRECISION_0-1:0] data_in [NPAR],
    input  logic                            data_in_valid,
    output logic                            data_in_ready,
    input  logic                            reload,
    output logic                            loaded,
    input  logic [AWIDTH-1:0]               addr0,
    input  logic                            ce0,
    output logic [BEAT_W-1:0]               q0
);

    localparam int unsigned IW = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1;

    typedef enum logic {
        LOAD = 1'b0,
        FULL = 1'b1
    } state_t;

    state_t              state, state_next;
    logic [AWIDTH-1:0]   wr_cnt, wr_cnt_next;
    logic                we;
    logic [BEAT_W-1:0]   word;
    logic [BEAT_W-1:0]   t0;
    logic [BEAT_W-1:0]   mem [IN_DEPTH];

    always_comb begin
        word = '0;
        for (int unsigned j = 0; j < NPAR; j++) begin
            word[j*KEY_BIAS_PRECISION_0 +: KEY_BIAS_PRECISION_0] = data_in[j];
        end
    end

    // Status outputs come from the state register only, never from data_in_valid.
    assign data_in_ready = (state == LOAD);
    assign loaded        = (state == FULL);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= LOAD;
            wr_cnt <= '0;
        end else begin
            state  <= state_next;
            wr_cnt <= wr_cnt_next;
        end
    end

    // Reload wins over a same-cycle handshake; that beat is dropped.
    always_comb begin
        state_next  = state;
        wr_cnt_next = wr_cnt;
        we          = 1'b0;
        if (reload) begin
            state_next  = LOAD;
            wr_cnt_next = '0;
        end else if (state == LOAD && data_in_valid) begin
            we = 1'b1;
            if (wr_cnt == AWIDTH'(IN_DEPTH - 1)) begin
                wr_cnt_next = '0;
                state_next  = FULL;
            end else begin
                wr_cnt_next = wr_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_cnt[IW-1:0]] <= word;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            t0 <= '0;
            q0 <= '0;
        end else if (ce0) begin
            t0 <= (addr0 < AWIDTH'(IN_DEPTH)) ? mem[addr0[IW-1:0]] : '0;
            q0 <= t0;
        end
    end

endmodule

// File: tb/tb_encoder_layer_0_attention_self_key_bias_sink.sv
// Self-checking bench for the key-bias sink: directed loads, random-gap and random-data
// loads against an array model, table-driven single reads, reload and async-reset cases.
module tb_encoder_layer_0_attention_self_key_bias_sink;

    localparam int DEPTH = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] data_in [1];
    logic        data_in_valid;
    logic        data_in_ready;
    logic        reload;
    logic        loaded;
    logic [5:0]  addr0;
    logic        ce0;
    logic [15:0] q0;

    logic [15:0] model_mem [DEPTH];
    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [5:0]  addr;
        logic [15:0] exp;
    } rd_vec_t;
    rd_vec_t vecs [7];

    encoder_layer_0_attention_self_key_bias_sink dut (
        .clk           (clk),
        .rst           (rst),
        .data_in       (data_in),
        .data_in_valid (data_in_valid),
        .data_in_ready (data_in_ready),
        .reload        (reload),
        .loaded        (loaded),
        .addr0         (addr0),
        .ce0           (ce0),
        .q0            (q0)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Loads a full tensor starting from an empty write pointer; the model records
    // each accepted beat at the next sequential index.
    task automatic stream(input logic [15:0] base, input bit gaps, input bit rnd);
        int cnt = 0;
        int cycles = 0;
        bit v;
        logic [15:0] val;
        while (cnt < DEPTH && cycles < 2000) begin
            v   = gaps ? bit'($urandom_range(0, 1)) : 1'b1;
            val = rnd ? 16'($urandom) : base + 16'(cnt);
            data_in[0]    = v ? val : (16'hFFFF ^ 16'(cnt));
            data_in_valid = v;
            if (!data_in_ready || loaded) check("ready_while_loading", {data_in_ready, loaded}, 32'h2);
            tick();
            if (v) begin
                model_mem[cnt] = val;
                cnt++;
            end
            cycles++;
        end
        data_in_valid = 1'b0;
        check("stream_complete", cnt, DEPTH);
        check("loaded_after_stream", loaded, 1);
        check("ready_low_after_stream", data_in_ready, 0);
    endtask

    task automatic readback_all(input string name);
        ce0 = 1'b1;
        for (int i = 0; i <= DEPTH; i++) begin
            addr0 = (i < DEPTH) ? 6'(i) : 6'd0;
            tick();
            if (i >= 1) check(name, q0, model_mem[i-1]);
        end
    endtask

    task automatic read_one(input logic [5:0] a, output logic [15:0] d);
        ce0   = 1'b1;
        addr0 = a;
        tick();
        tick();
        d = q0;
    endtask

    task automatic pulse_reload();
        reload = 1'b1;
        tick();
        reload = 1'b0;
        check("reload_loaded", loaded, 0);
        check("reload_ready", data_in_ready, 1);
    endtask

    initial begin
        logic [15:0] d;
        logic [15:0] held;

        vecs[0] = '{addr: 6'd0,  exp: 16'h0000};
        vecs[1] = '{addr: 6'd31, exp: 16'h001F};
        vecs[2] = '{addr: 6'd17, exp: 16'h0011};
        vecs[3] = '{addr: 6'd32, exp: 16'h0000};
        vecs[4] = '{addr: 6'd40, exp: 16'h0000};
        vecs[5] = '{addr: 6'd63, exp: 16'h0000};
        vecs[6] = '{addr: 6'd9,  exp: 16'h0009};

        rst = 1'b0; reload = 1'b0; data_in_valid = 1'b0; data_in[0] = '0;
        addr0 = '0; ce0 = 1'b0;
        #2;
        check("reset_ready", data_in_ready, 1);
        check("reset_loaded", loaded, 0);
        check("reset_q0", q0, 0);
        #10 rst = 1'b1;
        @(negedge clk);

        // Continuous stream 0..31: loaded must rise exactly after the 32nd edge.
        for (int i = 0; i < DEPTH; i++) begin
            data_in[0] = 16'(i); data_in_valid = 1'b1;
            check("loaded_low_during_burst", loaded, 0);
            tick();
            model_mem[i] = 16'(i);
        end
        data_in_valid = 1'b0;
        check("loaded_after_32", loaded, 1);
        check("ready_after_32", data_in_ready, 0);
        readback_all("readback_seq");

        foreach (vecs[k]) begin
            read_one(vecs[k].addr, d);
            check($sformatf("table_read_%0d", vecs[k].addr), d, vecs[k].exp);
        end

        // Valid while FULL must not write.
        for (int i = 0; i < 10; i++) begin
            data_in[0] = 16'hFFFF; data_in_valid = 1'b1;
            tick();
            check("full_ready_low", data_in_ready, 0);
        end
        data_in_valid = 1'b0;
        readback_all("readback_after_ignored");

        pulse_reload();
        stream(16'hA000, 1'b1, 1'b0);
        readback_all("readback_gaps");

        // Reload colliding with beat 5: that beat is dropped and the pointer restarts.
        pulse_reload();
        for (int i = 0; i < 5; i++) begin
            data_in[0] = 16'h7000 + 16'(i); data_in_valid = 1'b1;
            tick();
            model_mem[i] = 16'h7000 + 16'(i);
        end
        data_in[0] = 16'h7005; reload = 1'b1;
        tick();
        reload = 1'b0; data_in_valid = 1'b0;
        check("collide_loaded", loaded, 0);
        check("collide_ready", data_in_ready, 1);
        read_one(6'd5, d);
        check("collide_beat5_not_written", d, 16'hA005);
        read_one(6'd4, d);
        check("collide_beat4_written", d, 16'h7004);
        stream(16'h5000, 1'b0, 1'b0);
        readback_all("readback_after_reload");

        read_one(6'd40, d);
        check("out_of_range", d, 0);
        read_one(6'd7, held);
        check("addr7", held, 16'h5007);
        ce0 = 1'b0; addr0 = 6'd40;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("ce0_hold", q0, held);
        end

        // Async reset mid-load, then a fresh random load from address 0.
        pulse_reload();
        ce0 = 1'b1; addr0 = 6'd1;
        for (int i = 0; i < 13; i++) begin
            data_in[0] = 16'hB000 + 16'(i); data_in_valid = 1'b1;
            tick();
        end
        data_in_valid = 1'b0;
        tick();
        check("q0_before_async_rst", q0, 16'hB001);
        #2 rst = 1'b0;
        #1;
        check("async_rst_q0", q0, 0);
        check("async_rst_loaded", loaded, 0);
        check("async_rst_ready", data_in_ready, 1);
        #1 rst = 1'b1;
        @(negedge clk);
        stream(16'h0000, 1'b1, 1'b1);
        readback_all("readback_random");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
